// File: rtl/req_ack_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : req_ack_pkg
//  Purpose  : Shared types and constants for the req_ack_tx byte source:
//             handshake FSM state encoding, byte width and a helper that
//             sizes the FIFO occupancy count from the FIFO depth.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package req_ack_pkg;

   localparam int BYTE_W = 8;

   // Handshake FSM states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ_HI = 2'd1,
      ST_REQ_LO = 2'd2
   } state_e;

   // Occupancy must represent 0..DEPTH inclusive, hence one bit above the
   // pointer width.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : req_ack_pkg
`default_nettype wire

// File: rtl/req_ack_tx_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : byte_fifo
//  Purpose  : Synchronous single-clock byte FIFO with a show-ahead read port.
//             Overflowing writes and underflowing reads are ignored.
//  Ports    : CLK, RST      - clock, synchronous active-high reset
//             WR_EN, WR_DAT - write strobe and byte
//             RD_EN         - pop the head entry
//             RD_DAT        - head entry, visible combinationally
//             FULL, EMPTY   - registered status flags
//             LEVEL         - occupancy 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module byte_fifo
   import req_ack_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          WR_EN,
   input  logic [BYTE_W-1:0]             WR_DAT,
   input  logic                          RD_EN,
   output logic [BYTE_W-1:0]             RD_DAT,
   output logic                          FULL,
   output logic                          EMPTY,
   output logic [level_width(DEPTH)-1:0] LEVEL
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic              full_q;
   logic              empty_q;
   logic              wr_acc;
   logic              rd_acc;

   // Acceptance uses the registered flags, so a write while full is dropped
   // even if a pop happens on the same edge.
   assign wr_acc = WR_EN & ~full_q;
   assign rd_acc = RD_EN & ~empty_q;

   always_comb begin
      level_d = level_q;
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (!RST && wr_acc) begin
         mem_q[wr_ptr_q] <= WR_DAT;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
         empty_q <= (level_d == '0);
      end
   end

   assign RD_DAT = mem_q[rd_ptr_q];
   assign FULL   = full_q;
   assign EMPTY  = empty_q;
   assign LEVEL  = level_q;

endmodule : byte_fifo
`default_nettype wire

// File: rtl/req_ack_tx.sv
`default_nettype none
// ============================================================================
//  Module   : req_ack_tx
//  Purpose  : Byte-stream source. Buffers producer bytes in a FIFO and hands
//             each one to the consumer with a four-phase REQ/ACK handshake,
//             holding DAT stable while REQ is high. An ACK timeout and sticky
//             error flags expose a hung consumer or a dropped write.
//  Ports    : CLK, RST         - clock, synchronous active-high reset
//             WR_EN, WR_DAT    - producer write strobe and byte
//             FULL, EMPTY      - FIFO status (registered)
//             LEVEL            - FIFO occupancy
//             REQ, ACK, DAT    - handshake to/from the consumer
//             BUSY             - FSM not idle
//             OVF_ERR, TMO_ERR - sticky overflow / timeout flags
//             ERR_CLR          - clears both sticky flags
//  Revision : 1.0 - initial release
// ============================================================================
module req_ack_tx
   import req_ack_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TMO_CYC = 255,
   parameter int TMO_W   = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          WR_EN,
   input  logic [BYTE_W-1:0]             WR_DAT,
   output logic                          FULL,
   output logic                          EMPTY,
   output logic [level_width(DEPTH)-1:0] LEVEL,
   output logic                          REQ,
   input  logic                          ACK,
   output logic [BYTE_W-1:0]             DAT,
   output logic                          BUSY,
   output logic                          OVF_ERR,
   output logic                          TMO_ERR,
   input  logic                          ERR_CLR
);

   // Counter value on which the timeout fires; unused when TMO_CYC is 0.
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((TMO_CYC == 0) ? 0 : TMO_CYC - 1);
   localparam bit TMO_EN = (TMO_CYC != 0);

   state_e            state_q, state_d;
   logic              req_q,   req_d;
   logic [BYTE_W-1:0] dat_q,   dat_d;
   logic [TMO_W-1:0]  cnt_q,   cnt_d;
   logic              ovf_q,   ovf_d;
   logic              tmo_q,   tmo_d;
   logic              pop;
   logic              tmo_fire;
   logic [BYTE_W-1:0] head;
   logic              fifo_full;
   logic              fifo_empty;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK    (CLK),
      .RST    (RST),
      .WR_EN  (WR_EN),
      .WR_DAT (WR_DAT),
      .RD_EN  (pop),
      .RD_DAT (head),
      .FULL   (fifo_full),
      .EMPTY  (fifo_empty),
      .LEVEL  (LEVEL)
   );

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      dat_d    = dat_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;
      tmo_fire = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A high ACK here is left over from before a reset; wait it out.
            if (!fifo_empty && !ACK) begin
               pop     = 1'b1;
               req_d   = 1'b1;
               dat_d   = head;
               cnt_d   = '0;
               state_d = ST_REQ_HI;
            end
         end

         ST_REQ_HI: begin
            if (ACK) begin
               req_d   = 1'b0;
               state_d = ST_REQ_LO;
            end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
               // Abandon the byte; DAT keeps its value but is no longer offered.
               req_d    = 1'b0;
               tmo_fire = 1'b1;
               state_d  = ST_REQ_LO;
            end else begin
               cnt_d = cnt_q + TMO_W'(1);
            end
         end

         ST_REQ_LO: begin
            // Entering here always costs one cycle with REQ low.
            if (!ACK) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  req_d   = 1'b1;
                  dat_d   = head;
                  cnt_d   = '0;
                  state_d = ST_REQ_HI;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky flags: a set condition outranks a simultaneous clear.
   always_comb begin
      ovf_d = ovf_q;
      tmo_d = tmo_q;
      if (WR_EN && fifo_full) ovf_d = 1'b1;
      else if (ERR_CLR)       ovf_d = 1'b0;
      if (tmo_fire)           tmo_d = 1'b1;
      else if (ERR_CLR)       tmo_d = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         dat_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         dat_q   <= dat_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
      end
   end

   assign FULL    = fifo_full;
   assign EMPTY   = fifo_empty;
   assign REQ     = req_q;
   assign DAT     = dat_q;
   assign BUSY    = (state_q != ST_IDLE);
   assign OVF_ERR = ovf_q;
   assign TMO_ERR = tmo_q;

endmodule : req_ack_tx
`default_nettype wire

// File: tb/tb_req_ack_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req_ack_tx
//  Purpose  : Self-checking bench for req_ack_tx. Unit 0 has a 4-cycle ACK
//             timeout, unit 1 has the timeout disabled. Bytes expected on the
//             handshake are queued when written and popped by a monitor on
//             every REQ rise; flag checks are made inline by the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_req_ack_tx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst     [2];
   logic       wr_en   [2];
   logic [7:0] wr_dat  [2];
   logic       err_clr [2];
   logic       full    [2];
   logic       empty   [2];
   logic [3:0] level   [2];
   logic       req     [2];
   logic [7:0] dat     [2];
   logic       busy    [2];
   logic       ovf     [2];
   logic       tmo     [2];
   logic       ack_w   [2];

   // Consumer model controls
   logic       cons_on  [2];
   int         cons_dly [2];
   logic       cons_ack [2];
   logic       ack_man  [2];
   int         hi_cnt   [2];

   assign ack_w[0] = cons_on[0] ? cons_ack[0] : ack_man[0];
   assign ack_w[1] = cons_on[1] ? cons_ack[1] : ack_man[1];

   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   int         n_vec = 0;
   int         n_err = 0;

   // Monitor state
   logic       gap_chk     [2];
   int         burst_rises [2];
   int         gap         [2];
   logic [7:0] held        [2];
   logic       req_prev    [2];

   req_ack_tx #(.DEPTH(8), .TMO_CYC(4), .TMO_W(8)) u_dut0 (
      .CLK(clk), .RST(rst[0]), .WR_EN(wr_en[0]), .WR_DAT(wr_dat[0]),
      .FULL(full[0]), .EMPTY(empty[0]), .LEVEL(level[0]), .REQ(req[0]),
      .ACK(ack_w[0]), .DAT(dat[0]), .BUSY(busy[0]), .OVF_ERR(ovf[0]),
      .TMO_ERR(tmo[0]), .ERR_CLR(err_clr[0])
   );

   req_ack_tx #(.DEPTH(8), .TMO_CYC(0), .TMO_W(8)) u_dut1 (
      .CLK(clk), .RST(rst[1]), .WR_EN(wr_en[1]), .WR_DAT(wr_dat[1]),
      .FULL(full[1]), .EMPTY(empty[1]), .LEVEL(level[1]), .REQ(req[1]),
      .ACK(ack_w[1]), .DAT(dat[1]), .BUSY(busy[1]), .OVF_ERR(ovf[1]),
      .TMO_ERR(tmo[1]), .ERR_CLR(err_clr[1])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle(input int u, input int lim);
      bit done = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (!busy[u] && empty[u]) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      chk($sformatf("u%0d drain to idle", u), 32'(done), 32'd1);
   endtask

   // Consumer: raises ACK after REQ has been seen high cons_dly samples,
   // drops it the sample after REQ falls.
   initial begin
      for (int u = 0; u < 2; u++) begin
         cons_ack[u] = 1'b0;
         hi_cnt[u]   = 0;
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (!cons_on[u]) begin
               cons_ack[u] = 1'b0;
               hi_cnt[u]   = 0;
            end else if (!cons_ack[u] && req[u]) begin
               hi_cnt[u]++;
               if (hi_cnt[u] >= cons_dly[u]) cons_ack[u] = 1'b1;
            end else if (cons_ack[u] && !req[u]) begin
               cons_ack[u] = 1'b0;
               hi_cnt[u]   = 0;
            end else if (!req[u]) begin
               hi_cnt[u] = 0;
            end
         end
      end
   end

   // Monitor: checks each presented byte against the scoreboard, DAT
   // stability while REQ is high and, in burst mode, the REQ-low gap.
   initial begin
      logic [7:0] e;
      bit         have;
      for (int u = 0; u < 2; u++) begin
         burst_rises[u] = 0;
         gap[u]         = 0;
         held[u]        = 8'h00;
         req_prev[u]    = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (req[u] === 1'b1 && !req_prev[u]) begin
               have = 1'b0;
               e    = 8'h00;
               if (u == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
               if (u == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
               if (have) chk($sformatf("u%0d presented byte", u), 32'(dat[u]), 32'(e));
               else begin
                  n_vec++;
                  n_err++;
                  $display("FAIL u%0d unexpected byte: got %0h, expected none", u, dat[u]);
               end
               held[u] = dat[u];
               if (gap_chk[u]) begin
                  if (burst_rises[u] > 0)
                     chk($sformatf("u%0d REQ low gap", u), 32'(gap[u]), 32'd1);
                  burst_rises[u]++;
               end
               gap[u] = 0;
            end else if (req[u] === 1'b1) begin
               chk($sformatf("u%0d DAT hold", u), 32'(dat[u]), 32'(held[u]));
            end else begin
               gap[u]++;
            end
            if (!gap_chk[u]) burst_rises[u] = 0;
            req_prev[u] = (req[u] === 1'b1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst[u] = 1'b1; wr_en[u] = 1'b0; wr_dat[u] = 8'h00; err_clr[u] = 1'b0;
         cons_on[u] = 1'b0; cons_dly[u] = 1; ack_man[u] = 1'b0; gap_chk[u] = 1'b0;
      end
      tick(3);
      // ---------------- reset values ----------------
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d rst REQ", u),   32'(req[u]),   32'd0);
         chk($sformatf("u%0d rst DAT", u),   32'(dat[u]),   32'd0);
         chk($sformatf("u%0d rst FULL", u),  32'(full[u]),  32'd0);
         chk($sformatf("u%0d rst EMPTY", u), 32'(empty[u]), 32'd1);
         chk($sformatf("u%0d rst LEVEL", u), 32'(level[u]), 32'd0);
         chk($sformatf("u%0d rst BUSY", u),  32'(busy[u]),  32'd0);
         chk($sformatf("u%0d rst OVF", u),   32'(ovf[u]),   32'd0);
         chk($sformatf("u%0d rst TMO", u),   32'(tmo[u]),   32'd0);
         rst[u] = 1'b0;
      end
      tick();

      // ---------------- single byte, ACK 3 samples after REQ ----------------
      cons_on[0] = 1'b1; cons_dly[0] = 3;
      wr_en[0] = 1'b1; wr_dat[0] = 8'hA5; exp0.push_back(8'hA5);
      tick();                                   // edge k
      wr_en[0] = 1'b0;
      chk("single LEVEL after write", 32'(level[0]), 32'd1);
      chk("single REQ after write",   32'(req[0]),   32'd0);
      tick();                                   // edge k+1
      chk("single REQ k+1",  32'(req[0]),   32'd1);
      chk("single DAT k+1",  32'(dat[0]),   32'hA5);
      chk("single BUSY k+1", 32'(busy[0]),  32'd1);
      chk("single EMPTY k+1",32'(empty[0]), 32'd1);
      tick(2);                                  // edge k+3
      chk("single REQ k+3",  32'(req[0]),   32'd1);
      tick();                                   // edge k+4: ACK seen
      chk("single REQ fall", 32'(req[0]),   32'd0);
      chk("single BUSY REQ_LO", 32'(busy[0]), 32'd1);
      tick();                                   // edge k+5: ACK low seen
      chk("single BUSY idle", 32'(busy[0]), 32'd0);

      // ---------------- burst 01..08 ----------------
      cons_dly[0] = 1; gap_chk[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         wr_en[0] = 1'b1; wr_dat[0] = 8'(i); exp0.push_back(8'(i));
         tick();
      end
      wr_en[0] = 1'b0;
      wait_idle(0, 100);
      gap_chk[0] = 1'b0;
      chk("burst OVF",    32'(ovf[0]),     32'd0);
      chk("burst EMPTY",  32'(empty[0]),   32'd1);
      chk("burst queue",  32'(exp0.size()), 32'd0);

      // ---------------- timeout (TMO_CYC=4) ----------------
      cons_on[0] = 1'b0; ack_man[0] = 1'b0;
      tick();
      wr_en[0] = 1'b1; wr_dat[0] = 8'h3C; exp0.push_back(8'h3C);
      tick();                                   // edge k
      wr_dat[0] = 8'h5A; exp0.push_back(8'h5A);
      tick();                                   // edge k+1
      wr_en[0] = 1'b0;
      chk("tmo REQ k+1", 32'(req[0]), 32'd1);
      chk("tmo DAT k+1", 32'(dat[0]), 32'h3C);
      for (int i = 2; i <= 4; i++) begin
         tick();
         chk("tmo REQ held", 32'(req[0]), 32'd1);
      end
      tick();                                   // edge k+5
      chk("tmo REQ fall", 32'(req[0]),  32'd0);
      chk("tmo ERR set",  32'(tmo[0]),  32'd1);
      chk("tmo BUSY",     32'(busy[0]), 32'd1);
      tick();                                   // edge k+6
      chk("tmo next REQ", 32'(req[0]), 32'd1);
      chk("tmo next DAT", 32'(dat[0]), 32'h5A);
      tick(3);                                  // edge k+9
      err_clr[0] = 1'b1;
      tick();                                   // edge k+10: second timeout
      err_clr[0] = 1'b0;
      chk("tmo set beats clr", 32'(tmo[0]), 32'd1);
      chk("tmo second fall",   32'(req[0]), 32'd0);
      err_clr[0] = 1'b1;
      tick();                                   // edge k+11
      err_clr[0] = 1'b0;
      chk("tmo cleared",  32'(tmo[0]),  32'd0);
      chk("tmo idle",     32'(busy[0]), 32'd0);

      // ---------------- reset mid-transfer ----------------
      tick();
      for (int i = 1; i <= 5; i++) begin
         wr_en[0] = 1'b1; wr_dat[0] = 8'(8'h11 * i); exp0.push_back(8'(8'h11 * i));
         tick();                                // edges k..k+4
      end
      wr_en[0] = 1'b0;
      tick();                                   // edge k+5: 0x11 times out
      chk("rstmid TMO before", 32'(tmo[0]), 32'd1);
      tick();                                   // edge k+6: 0x22 in REQ_HI
      chk("rstmid REQ before",   32'(req[0]),   32'd1);
      chk("rstmid DAT before",   32'(dat[0]),   32'h22);
      chk("rstmid LEVEL before", 32'(level[0]), 32'd3);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      exp0.delete();
      chk("rstmid REQ",   32'(req[0]),   32'd0);
      chk("rstmid LEVEL", 32'(level[0]), 32'd0);
      chk("rstmid EMPTY", 32'(empty[0]), 32'd1);
      chk("rstmid BUSY",  32'(busy[0]),  32'd0);
      chk("rstmid TMO",   32'(tmo[0]),   32'd0);
      chk("rstmid OVF",   32'(ovf[0]),   32'd0);
      ack_man[0] = 1'b1;
      wr_en[0] = 1'b1; wr_dat[0] = 8'h66; exp0.push_back(8'h66);
      tick();
      wr_en[0] = 1'b0;
      chk("stale ACK LEVEL", 32'(level[0]), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("stale ACK REQ low", 32'(req[0]), 32'd0);
         tick();
      end
      ack_man[0] = 1'b0;
      tick();
      chk("stale ACK released REQ", 32'(req[0]), 32'd1);
      chk("stale ACK released DAT", 32'(dat[0]), 32'h66);
      cons_on[0] = 1'b1; cons_dly[0] = 1;
      wait_idle(0, 50);

      // ---------------- overflow (unit 1, no timeout) ----------------
      for (int i = 0; i < 10; i++) begin
         wr_en[1] = 1'b1; wr_dat[1] = 8'(8'h80 + i);
         if (i < 9) exp1.push_back(8'(8'h80 + i));
         tick();
         if (i == 8) begin
            chk("ovf LEVEL full", 32'(level[1]), 32'd8);
            chk("ovf FULL",       32'(full[1]),  32'd1);
            chk("ovf ERR clear",  32'(ovf[1]),   32'd0);
            chk("ovf DAT head",   32'(dat[1]),   32'h80);
         end
      end
      wr_en[1] = 1'b0;
      chk("ovf ERR set",     32'(ovf[1]),   32'd1);
      chk("ovf LEVEL after", 32'(level[1]), 32'd8);
      err_clr[1] = 1'b1;
      tick();
      err_clr[1] = 1'b0;
      chk("ovf ERR_CLR", 32'(ovf[1]), 32'd0);
      err_clr[1] = 1'b1; wr_en[1] = 1'b1; wr_dat[1] = 8'hFF;
      tick();
      err_clr[1] = 1'b0; wr_en[1] = 1'b0;
      chk("ovf set beats clr", 32'(ovf[1]),   32'd1);
      chk("ovf drop LEVEL",    32'(level[1]), 32'd8);
      err_clr[1] = 1'b1;
      tick();
      err_clr[1] = 1'b0;

      // ---------------- timeout disabled: ACK low for 1000 cycles ----------------
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (i % 250 == 249) chk("notmo REQ held", 32'(req[1]), 32'd1);
      end
      chk("notmo TMO_ERR", 32'(tmo[1]), 32'd0);
      chk("notmo DAT",     32'(dat[1]), 32'h80);
      chk("notmo BUSY",    32'(busy[1]), 32'd1);
      cons_on[1] = 1'b1; cons_dly[1] = 1;
      wait_idle(1, 200);
      chk("drain LEVEL", 32'(level[1]), 32'd0);
      chk("drain OVF",   32'(ovf[1]),   32'd0);

      tick(2);
      chk("u0 scoreboard empty", 32'(exp0.size()), 32'd0);
      chk("u1 scoreboard empty", 32'(exp1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_req_ack_tx
`default_nettype wire
